// File: rtl/pipeline_defs.sv
// Opcode groups, ALU op codes and decoded-instruction types shared by the
// instruction decoder and the hazard controller.
package pipeline_defs;

  localparam logic [2:0] GRP_LOAD   = 3'b000;
  localparam logic [2:0] GRP_I      = 3'b001;
  localparam logic [2:0] GRP_STORE  = 3'b010;
  localparam logic [2:0] GRP_R      = 3'b011;
  localparam logic [2:0] GRP_BRANCH = 3'b110;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9,
    ALU_MUL  = 4'd10
  } alu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } hz_state_e;

  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       is_load;
    logic       is_mul;
    logic       is_branch;
  } hz_dec_t;

endpackage

// File: rtl/hazard_decode.sv
// Combinational field extraction and hazard-relevant classification of the
// instruction sitting in IF/ID.
module hazard_decode
  import pipeline_defs::*;
(
  input  logic [31:0] instr_i,
  output hz_dec_t     dec_o
);

  logic [6:0] op;
  logic [2:0] grp;
  logic       unused_bits;

  assign op  = instr_i[6:0];
  assign grp = instr_i[6:4];

  // Funct bits that do not influence hazard detection.
  assign unused_bits = ^{instr_i[31], instr_i[29:26], instr_i[14:12]};

  always_comb begin
    dec_o           = '0;
    dec_o.rs1       = instr_i[19:15];
    dec_o.rs2       = instr_i[24:20];
    dec_o.rd        = instr_i[11:7];
    dec_o.uses_rs1  = (op != 7'd0);
    dec_o.uses_rs2  = (grp == GRP_R) || (grp == GRP_STORE) || (grp == GRP_BRANCH);
    dec_o.is_load   = (grp == GRP_LOAD) && (op != 7'd0);
    dec_o.is_mul    = (grp == GRP_R) && instr_i[25] && !instr_i[30];
    dec_o.is_branch = (grp == GRP_BRANCH);
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Load-use, taken-branch and multi-cycle MUL hazard control for the 5-stage
// core; drives the decoder bubble and the front-end write enables.
module hazard_ctrl
  import pipeline_defs::*;
#(
  parameter int MUL_CYCLES = 1,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [31:0]      instr_i,
  input  logic             branch_taken_i,
  output logic             noop_o,
  output logic             pc_write_o,
  output logic             ifid_write_o,
  output logic             idex_write_o,
  output logic             ifid_flush_o,
  output logic             mul_busy_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  localparam logic [4:0] MUL_LOAD = 5'(MUL_CYCLES - 1);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  hz_dec_t dec;

  hazard_decode u_decode (
    .instr_i (instr_i),
    .dec_o   (dec)
  );

  hz_state_e        state_q, state_d;
  logic [4:0]       ex_rd_q, ex_rd_d;
  logic             ex_load_q, ex_load_d;
  logic [4:0]       mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic             load_use;

  assign load_use = ex_load_q && (ex_rd_q != 5'd0) &&
                    ((dec.uses_rs1 && (dec.rs1 == ex_rd_q)) ||
                     (dec.uses_rs2 && (dec.rs2 == ex_rd_q)));

  // Priority: MUL occupancy, then load-use, then taken-branch flush.
  always_comb begin
    noop_o       = 1'b1;
    pc_write_o   = 1'b0;
    ifid_write_o = 1'b0;
    idex_write_o = 1'b0;
    ifid_flush_o = 1'b0;
    mul_busy_o   = 1'b0;
    if (state_q == ST_RUN) begin
      if (mul_cnt_q != 5'd0) begin
        noop_o     = 1'b0;
        mul_busy_o = 1'b1;
      end else if (load_use) begin
        idex_write_o = 1'b1;
      end else begin
        noop_o       = 1'b0;
        pc_write_o   = 1'b1;
        ifid_write_o = 1'b1;
        idex_write_o = 1'b1;
        ifid_flush_o = dec.is_branch && branch_taken_i;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ex_rd_d     = ex_rd_q;
    ex_load_d   = ex_load_q;
    mul_cnt_d   = mul_cnt_q;
    stall_cnt_d = stall_cnt_q;

    if ((state_q == ST_IDLE) && start_i)
      state_d = ST_RUN;

    if (idex_write_o) begin
      ex_rd_d   = noop_o ? 5'd0 : dec.rd;
      ex_load_d = noop_o ? 1'b0 : dec.is_load;
    end

    if (mul_cnt_q != 5'd0)
      mul_cnt_d = mul_cnt_q - 5'd1;
    else if (idex_write_o && !noop_o && dec.is_mul)
      mul_cnt_d = MUL_LOAD;

    if ((state_q == ST_RUN) && !pc_write_o)
      stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ex_rd_q     <= 5'd0;
      ex_load_q   <= 1'b0;
      mul_cnt_q   <= 5'd0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_rd_q     <= ex_rd_d;
      ex_load_q   <= ex_load_d;
      mul_cnt_q   <= mul_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt_o = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed scoreboard bench for hazard_ctrl with MUL_CYCLES=4.
module tb_hazard_ctrl;

  localparam int CNT_W = 16;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] LW_X5    = 32'h0000_A283;
  localparam logic [31:0] ADD_X5   = 32'h0022_8333;
  localparam logic [31:0] LW_X0    = 32'h0000_A003;
  localparam logic [31:0] ADD_X0   = 32'h0020_0333;
  localparam logic [31:0] BEQ_X1   = 32'h0020_8463;
  localparam logic [31:0] BEQ_X5   = 32'h0022_8463;
  localparam logic [31:0] MUL_X3   = 32'h0220_81B3;

  // {noop, pc_write, ifid_write, idex_write, ifid_flush, mul_busy}
  localparam logic [5:0] C_IDLE = 6'b100000;
  localparam logic [5:0] C_RUN  = 6'b011100;
  localparam logic [5:0] C_LU   = 6'b100100;
  localparam logic [5:0] C_FL   = 6'b011110;
  localparam logic [5:0] C_MUL  = 6'b000001;

  logic             clk = 1'b0;
  logic             rst_i = 1'b1;
  logic             start_i = 1'b0;
  logic [31:0]      instr_i = NOP;
  logic             branch_taken_i = 1'b0;
  logic             noop_o, pc_write_o, ifid_write_o, idex_write_o;
  logic             ifid_flush_o, mul_busy_o;
  logic [CNT_W-1:0] stall_cnt_o;

  int checks = 0;
  int failures = 0;

  logic [21:0] exp_q[$];
  string       name_q[$];

  always #5 clk = ~clk;

  hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(CNT_W)) dut (
    .clk_i          (clk),
    .rst_i          (rst_i),
    .start_i        (start_i),
    .instr_i        (instr_i),
    .branch_taken_i (branch_taken_i),
    .noop_o         (noop_o),
    .pc_write_o     (pc_write_o),
    .ifid_write_o   (ifid_write_o),
    .idex_write_o   (idex_write_o),
    .ifid_flush_o   (ifid_flush_o),
    .mul_busy_o     (mul_busy_o),
    .stall_cnt_o    (stall_cnt_o)
  );

  task automatic cyc(input logic rst, input logic start, input logic [31:0] instr,
                     input logic bt, input logic [5:0] ctl, input int cnt, input string nm);
    @(posedge clk);
    #1;
    rst_i          = rst;
    start_i        = start;
    instr_i        = instr;
    branch_taken_i = bt;
    exp_q.push_back({ctl, 16'(cnt)});
    name_q.push_back(nm);
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [21:0] exp_v;
      logic [21:0] got_v;
      string       nm;
      exp_v = exp_q.pop_front();
      nm    = name_q.pop_front();
      got_v = {noop_o, pc_write_o, ifid_write_o, idex_write_o, ifid_flush_o,
               mul_busy_o, stall_cnt_o};
      checks++;
      if (got_v !== exp_v) begin
        failures++;
        $display("FAIL %s: got ctl=%b cnt=%0d, expected ctl=%b cnt=%0d",
                 nm, got_v[21:16], got_v[15:0], exp_v[21:16], exp_v[15:0]);
      end
    end
  end

  initial begin
    cyc(1, 0, NOP, 0, C_IDLE, 0, "reset");
    for (int i = 0; i < 5; i++) cyc(0, 0, NOP, 0, C_IDLE, 0, "idle_gate");
    cyc(0, 1, NOP, 0, C_IDLE, 0, "start_edge");
    cyc(0, 0, NOP, 0, C_RUN, 0, "run_first");
    // load-use
    cyc(0, 0, LW_X5, 0, C_RUN, 0, "lw_x5");
    cyc(0, 0, ADD_X5, 0, C_LU, 0, "loaduse_stall");
    cyc(0, 0, ADD_X5, 0, C_RUN, 1, "loaduse_resume");
    // x0 exemption
    cyc(0, 0, LW_X0, 0, C_RUN, 1, "lw_x0");
    cyc(0, 0, ADD_X0, 0, C_RUN, 1, "x0_no_stall");
    // branch
    cyc(0, 0, BEQ_X1, 1, C_FL, 1, "branch_taken");
    cyc(0, 0, BEQ_X1, 0, C_RUN, 1, "branch_not_taken");
    // MUL occupancy with a taken branch waiting in ID
    cyc(0, 0, MUL_X3, 0, C_RUN, 1, "mul_issue");
    cyc(0, 0, BEQ_X1, 1, C_MUL, 1, "mul_busy1");
    cyc(0, 0, BEQ_X1, 1, C_MUL, 2, "mul_busy2");
    cyc(0, 0, NOP, 0, C_MUL, 3, "mul_busy3");
    cyc(0, 0, NOP, 0, C_RUN, 4, "mul_done");
    // branch stalled on a load, then re-evaluated
    cyc(0, 0, LW_X5, 0, C_RUN, 4, "lw_x5_b");
    cyc(0, 0, BEQ_X5, 1, C_LU, 4, "branch_on_load");
    cyc(0, 0, BEQ_X5, 1, C_FL, 5, "branch_after_load");
    // reset in the second busy cycle
    cyc(0, 0, MUL_X3, 0, C_RUN, 5, "mul_issue2");
    cyc(0, 0, NOP, 0, C_MUL, 5, "mul2_busy1");
    cyc(1, 0, NOP, 0, C_MUL, 6, "mul2_busy2_rst");
    cyc(0, 0, NOP, 0, C_IDLE, 0, "post_reset");
    cyc(0, 0, NOP, 0, C_IDLE, 0, "post_reset_idle");

    for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
    end
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
